// File: rtl/md_in_stage_pkg.sv
// Shared definitions for the multiply/divide unit: md_op field positions,
// funct3 codes, the signs vector bit order and the pipeline payload structs.
// The result post-processor imports this package to decode signs/md_op.
package md_in_stage_pkg;

  localparam int unsigned MD_XLEN = 64;
  localparam int unsigned MD_WLEN = 32;
  localparam int unsigned MD_OPW  = 4;

  // md_op = {W, funct3}
  localparam int unsigned MD_W   = 3;
  localparam int unsigned MD_DIV = 2;
  localparam int unsigned MD_F1  = 1;
  localparam int unsigned MD_F0  = 0;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // signs bit order: multiply = {sign(A), sign(B)}, divide = {sign(B), sign(A)}.
  // For divides bit 0 is the dividend sign (remainder sign); quotient is
  // negated when the two bits differ.
  localparam int unsigned SIGNS_MUL_A = 1;
  localparam int unsigned SIGNS_MUL_B = 0;
  localparam int unsigned SIGNS_DIV_B = 1;
  localparam int unsigned SIGNS_DIV_A = 0;

  // Most-negative values of the extended operand for 64-bit and word ops.
  localparam logic [MD_XLEN-1:0] MD_MIN64  = 64'h8000_0000_0000_0000;
  localparam logic [MD_XLEN-1:0] MD_MIN32X = 64'hFFFF_FFFF_8000_0000;

  // Raw request held in stage 1.
  typedef struct packed {
    logic [MD_XLEN-1:0] rs1;
    logic [MD_XLEN-1:0] rs2;
    logic [MD_OPW-1:0]  md_op;
  } md_req_t;

  // Prepared request held in stage 2.
  typedef struct packed {
    logic [MD_XLEN-1:0] a;
    logic [MD_XLEN-1:0] b;
    logic [1:0]         signs;
    logic [MD_OPW-1:0]  md_op;
    logic               dz;
    logic               ovf;
  } md_prep_t;

  // rs1 is unsigned only for MULHU, DIVU, REMU.
  function automatic logic op_a_signed(input logic [MD_OPW-1:0] op);
    case (op[2:0])
      F3_MULHU, F3_DIVU, F3_REMU: op_a_signed = 1'b0;
      default:                    op_a_signed = 1'b1;
    endcase
  endfunction

  // rs2 is additionally unsigned for MULHSU.
  function automatic logic op_b_signed(input logic [MD_OPW-1:0] op);
    case (op[2:0])
      F3_MULHSU, F3_MULHU, F3_DIVU, F3_REMU: op_b_signed = 1'b0;
      default:                               op_b_signed = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/md_operand_ext.sv
// Single-operand preparation: word extension, sign detection and
// two's-complement magnitude. Purely combinational.
//   op        in   raw 64-bit register operand
//   word      in   use low 32 bits, extended
//   is_signed in   operand is interpreted as signed
//   ext       out  extended operand
//   mag       out  magnitude if signed and negative, else ext
//   neg       out  operand is signed and negative
module md_operand_ext
  import md_in_stage_pkg::*;
(
  input  logic [MD_XLEN-1:0] op,
  input  logic               word,
  input  logic               is_signed,
  output logic [MD_XLEN-1:0] ext,
  output logic [MD_XLEN-1:0] mag,
  output logic               neg
);

  always_comb begin
    ext = op;
    if (word) begin
      ext = {{MD_WLEN{is_signed & op[MD_WLEN-1]}}, op[MD_WLEN-1:0]};
    end
    neg = is_signed & ext[MD_XLEN-1];
    // The most-negative value negates to itself and is read as unsigned.
    mag = neg ? (~ext + MD_XLEN'(1)) : ext;
  end

endmodule

// File: rtl/md_in_stage.sv
// Operand front end of the multiply/divide unit. Two-stage elastic pipeline:
// S1 registers the raw request, S2 registers magnitudes, signs and flags.
//   clk_i, rst_i             clock, asynchronous active-high reset
//   flush_i                  drop all in-flight requests
//   in_valid_i/in_ready_o    request handshake (in_ready_o is combinational)
//   rs1_i, rs2_i, md_op_i    raw operands and {W, funct3}
//   out_valid_o/out_ready_i  prepared-request handshake
//   a_o, b_o                 operand magnitudes (or raw extended operands)
//   signs_o, md_op_o         sign vector and forwarded op for post-processing
//   dz_o, ovf_o              divide-by-zero and signed-overflow flags
module md_in_stage
  import md_in_stage_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [MD_XLEN-1:0] rs1_i,
  input  logic [MD_XLEN-1:0] rs2_i,
  input  logic [MD_OPW-1:0]  md_op_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [MD_XLEN-1:0] a_o,
  output logic [MD_XLEN-1:0] b_o,
  output logic [1:0]         signs_o,
  output logic [MD_OPW-1:0]  md_op_o,
  output logic               dz_o,
  output logic               ovf_o
);

  logic     s1_valid;
  logic     s2_valid;
  md_req_t  s1_q;
  md_prep_t s2_q;
  md_prep_t s2_d;

  logic s2_ready_c;
  logic accept_c;
  logic s1_adv_c;

  logic               word_c;
  logic               a_sgn_c;
  logic               b_sgn_c;
  logic [MD_XLEN-1:0] a_ext_c;
  logic [MD_XLEN-1:0] b_ext_c;
  logic [MD_XLEN-1:0] a_mag_c;
  logic [MD_XLEN-1:0] b_mag_c;
  logic               a_neg_c;
  logic               b_neg_c;

  // Handshake: S2 frees when empty or draining; S1 frees when empty or advancing.
  assign s2_ready_c = !s2_valid || out_ready_i;
  assign in_ready_o = !s1_valid || s2_ready_c;
  assign accept_c   = in_valid_i && in_ready_o;
  assign s1_adv_c   = s1_valid && s2_ready_c;

  assign word_c  = s1_q.md_op[MD_W];
  assign a_sgn_c = op_a_signed(s1_q.md_op);
  assign b_sgn_c = op_b_signed(s1_q.md_op);

  md_operand_ext u_ext_a (
    .op        (s1_q.rs1),
    .word      (word_c),
    .is_signed (a_sgn_c),
    .ext       (a_ext_c),
    .mag       (a_mag_c),
    .neg       (a_neg_c)
  );

  md_operand_ext u_ext_b (
    .op        (s1_q.rs2),
    .word      (word_c),
    .is_signed (b_sgn_c),
    .ext       (b_ext_c),
    .mag       (b_mag_c),
    .neg       (b_neg_c)
  );

  // S2 payload: sign vector order depends on multiply vs divide.
  always_comb begin
    s2_d       = '0;
    s2_d.a     = a_mag_c;
    s2_d.b     = b_mag_c;
    s2_d.md_op = s1_q.md_op;
    if (s1_q.md_op[MD_DIV]) begin
      s2_d.signs[SIGNS_DIV_B] = b_neg_c;
      s2_d.signs[SIGNS_DIV_A] = a_neg_c;
      s2_d.dz  = (b_ext_c == '0);
      // Overflow is judged at the operating width (word ops: sext 0x8000_0000).
      s2_d.ovf = a_sgn_c && (b_ext_c == '1) &&
                 (a_ext_c == (word_c ? MD_MIN32X : MD_MIN64));
    end else begin
      s2_d.signs[SIGNS_MUL_A] = a_neg_c;
      s2_d.signs[SIGNS_MUL_B] = b_neg_c;
    end
  end

  // Stage valid bits; flush wins over accept and advance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (accept_c) begin
        s1_valid <= 1'b1;
      end else if (s1_adv_c) begin
        s1_valid <= 1'b0;
      end
      if (s2_ready_c) begin
        s2_valid <= s1_valid;
      end
    end
  end

  // Stage payloads; S2 only loads on advance so a stalled output stays put.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (!flush_i) begin
      if (accept_c) begin
        s1_q <= '{rs1: rs1_i, rs2: rs2_i, md_op: md_op_i};
      end
      if (s1_adv_c) begin
        s2_q <= s2_d;
      end
    end
  end

  assign out_valid_o = s2_valid;
  assign a_o         = s2_q.a;
  assign b_o         = s2_q.b;
  assign signs_o     = s2_q.signs;
  assign md_op_o     = s2_q.md_op;
  assign dz_o        = s2_q.dz;
  assign ovf_o       = s2_q.ovf;

endmodule

// File: tb/tb_md_in_stage.sv
// Directed self-checking bench for md_in_stage.
module tb_md_in_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [3:0]  md_op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [1:0]  signs;
  logic [3:0]  md_op_out;
  logic        dz;
  logic        ovf;

  int checks;
  int errors;

  md_in_stage dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .md_op_i     (md_op),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .a_o         (a),
    .b_o         (b),
    .signs_o     (signs),
    .md_op_o     (md_op_out),
    .dz_o        (dz),
    .ovf_o       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {out_valid, a, b, signs, md_op, dz, ovf}
  function automatic logic [136:0] obs();
    return {out_valid, a, b, signs, md_op_out, dz, ovf};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle into an empty front stage.
  task automatic issue(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
    in_valid = 1'b1;
    md_op    = op;
    rs1      = x;
    rs2      = y;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    checks++;
    if (obs() !== 137'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", obs());
    end
    rst = 1'b0;
  endtask

  task automatic test_prep_vectors();
    logic [3:0]   t_op[8];
    logic [63:0]  t_rs1[8];
    logic [63:0]  t_rs2[8];
    logic [136:0] t_exp[8];
    // DIV -7 / 2
    t_op[0] = 4'b0100; t_rs1[0] = 64'hFFFF_FFFF_FFFF_FFF9; t_rs2[0] = 64'd2;
    t_exp[0] = {1'b1, 64'd7, 64'd2, 2'b01, 4'b0100, 1'b0, 1'b0};
    // MULHSU -1 * 0xFFFF..FFFF (rs2 unsigned)
    t_op[1] = 4'b0010; t_rs1[1] = 64'hFFFF_FFFF_FFFF_FFFF; t_rs2[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    t_exp[1] = {1'b1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 4'b0010, 1'b0, 1'b0};
    // DIVUW by zero, dividend zero-extended from low word
    t_op[2] = 4'b1101; t_rs1[2] = 64'hDEAD_BEEF_8000_0000; t_rs2[2] = 64'd0;
    t_exp[2] = {1'b1, 64'h0000_0000_8000_0000, 64'd0, 2'b00, 4'b1101, 1'b1, 1'b0};
    // REM most-negative / -1
    t_op[3] = 4'b0110; t_rs1[3] = 64'h8000_0000_0000_0000; t_rs2[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    t_exp[3] = {1'b1, 64'h8000_0000_0000_0000, 64'd1, 2'b11, 4'b0110, 1'b0, 1'b1};
    // MULW: low words -2 and 3, upper halves ignored
    t_op[4] = 4'b1000; t_rs1[4] = 64'h0000_0001_FFFF_FFFE; t_rs2[4] = 64'h1234_5678_0000_0003;
    t_exp[4] = {1'b1, 64'd2, 64'd3, 2'b10, 4'b1000, 1'b0, 1'b0};
    // MULHU: raw operands pass through
    t_op[5] = 4'b0011; t_rs1[5] = 64'hFFFF_FFFF_FFFF_FFFF; t_rs2[5] = 64'h8000_0000_0000_0000;
    t_exp[5] = {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2'b00, 4'b0011, 1'b0, 1'b0};
    // DIV -5 / 0: signed divide by zero
    t_op[6] = 4'b0100; t_rs1[6] = 64'hFFFF_FFFF_FFFF_FFFB; t_rs2[6] = 64'd0;
    t_exp[6] = {1'b1, 64'd5, 64'd0, 2'b01, 4'b0100, 1'b1, 1'b0};
    // MUL most-negative * -1: no overflow flag for multiplies
    t_op[7] = 4'b0000; t_rs1[7] = 64'h8000_0000_0000_0000; t_rs2[7] = 64'hFFFF_FFFF_FFFF_FFFF;
    t_exp[7] = {1'b1, 64'h8000_0000_0000_0000, 64'd1, 2'b11, 4'b0000, 1'b0, 1'b0};

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(t_op[i], t_rs1[i], t_rs2[i]);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_early_valid got=%b want=0", i, out_valid);
      end
      step();
      checks++;
      if (obs() !== t_exp[i]) begin
        errors++;
        $display("FAIL vec%0d_outputs got=%h want=%h", i, obs(), t_exp[i]);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    int           sent;
    int           got;
    logic         prev_stall;
    logic         acc;
    logic [136:0] held;
    logic [136:0] exp;
    sent = 0;
    got = 0;
    prev_stall = 1'b0;
    held = '0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      out_ready = (c >= 3);
      if (sent < 4) begin
        in_valid = 1'b1;
        md_op    = 4'b0000;
        rs1      = 64'(0) - 64'(sent + 1);
        rs2      = 64'(10 + sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 2) begin
        checks++;
        if (in_ready !== 1'b0 || sent !== 2) begin
          errors++;
          $display("FAIL b2b_ready_drop in_ready=%b accepted=%0d want in_ready=0 accepted=2", in_ready, sent);
        end
      end
      if (prev_stall) begin
        checks++;
        if (obs() !== held) begin
          errors++;
          $display("FAIL b2b_stall_hold got=%h want=%h", obs(), held);
        end
      end
      if (out_valid && out_ready) begin
        exp = {1'b1, 64'(got + 1), 64'(10 + got), 2'b10, 4'b0000, 1'b0, 1'b0};
        checks++;
        if (obs() !== exp) begin
          errors++;
          $display("FAIL b2b_out%0d got=%h want=%h", got, obs(), exp);
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      held = obs();
      acc = in_valid && in_ready;
      step();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got !== 4) begin
      errors++;
      $display("FAIL b2b_count got=%0d want=4", got);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_extra%0d out_valid=%b want=0", k, out_valid);
      end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    md_op     = 4'b0000;
    rs1 = 64'h55; rs2 = 64'd1;
    step();
    rs1 = 64'h66; rs2 = 64'd2;
    step();
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_prefill out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    flush = 1'b1;
    rs1 = 64'h77; rs2 = 64'd3;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_in_ready got=%b want=1", in_ready);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_leak%0d out_valid=%b a=%h want out_valid=0", k, out_valid, a);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [136:0] exp;
    out_ready = 1'b1;
    issue(4'b0000, 64'd3, 64'd4);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_immediate out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_release_ready got=%b want=1", in_ready);
    end
    issue(4'b0101, 64'd100, 64'd7);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_stale got out_valid=%b a=%h want out_valid=0", out_valid, a);
    end
    step();
    exp = {1'b1, 64'd100, 64'd7, 2'b00, 4'b0101, 1'b0, 1'b0};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL areset_first_req got=%h want=%h", obs(), exp);
    end
    step();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rs1       = '0;
    rs2       = '0;
    md_op     = '0;
    #1;
    test_reset();
    test_prep_vectors();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_in_stage.md
# md_in_stage

Operand front end for the 64-bit multiply/divide unit. Accepts a raw M-extension request (two 64-bit register operands plus the 4-bit md_op code) and produces, over a two-stage elastic pipeline, the unsigned operand magnitudes, the 2-bit sign vector and a forwarded op code for the iterative core. It is the input-side counterpart of the result post-processor: that block consumes the `signs`/`md_op` pair produced here and applies the final negation and selection. It also flags divide-by-zero and signed overflow so the core can short-circuit.

## Interface
- No parameters; datapath fixed at 64 bits.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  kill all in-flight requests.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  stage 1 can accept.
- rs1_i  in  64  operand A / dividend.
- rs2_i  in  64  operand B / divisor.
- md_op_i  in  4  {W, funct3}; bit2=1 divide, bit3=1 word op.
- out_valid_o  out  1  prepared request valid.
- out_ready_i  in  1  core accepts.
- a_o  out  64  magnitude or raw operand A.
- b_o  out  64  magnitude or raw operand B.
- signs_o  out  2  sign vector for post-processing.
- md_op_o  out  4  forwarded md_op.
- dz_o  out  1  divide op with B == 0.
- ovf_o  out  1  signed divide, A = most-negative, B = -1.

## Operation
- Word ops (md_op[3]=1): operands become the low 32 bits, sign-extended when signed, zero-extended for unsigned divides (md_op[2:0]=101/111); MULW sign-extends both.
- Signedness per md_op[2:0]:
  - 000 MUL and 001 MULH: both signed.
  - 010 MULHSU: rs1 signed, rs2 unsigned.
  - 011 MULHU: both unsigned.
  - 100 DIV and 110 REM: both signed.
  - 101 DIVU and 111 REMU: both unsigned.
- Multiply: signs_o = {sign(A), sign(B)}, with a bit forced 0 for each unsigned operand.
- Divide: signs_o = {sign(B), sign(A)}. Bit 0 is the dividend sign, which sets the remainder sign. Quotient is negated when the two bits differ.
- a_o/b_o: two's-complement magnitude when the operand is signed and negative, else the extended operand unchanged.
- Most-negative magnitude is 0x8000_0000_0000_0000 and is passed as an unsigned value (64-bit, or 0x8000_0000 zero-extended for word ops).
- dz_o is set only for divide ops with the extended B == 0. ovf_o is set only for signed divides with extended A = most-negative and B = all-ones. Both are 0 for multiplies.
- Pipeline stages:
  - S1 registers the raw request.
  - S2 registers the extended magnitudes, signs and flags.
  - Each stage holds a valid bit. There is no FSM beyond the per-stage valid/hold.

## Timing
- Reset values: all valid bits 0, out_valid_o=0, in_ready_o=1, a_o=b_o=0, signs_o=0, md_op_o=0, dz_o=ovf_o=0.
- Accept on in_valid_i && in_ready_o. out_valid_o rises 2 cycles after acceptance when unstalled. Throughput is 1 request/cycle.
- in_ready_o = !s1_valid || !s2_valid || out_ready_i. This is combinational from out_ready_i, with no dependence on in_valid_i.
- Stall: out_valid_o && !out_ready_i holds every S2 output stable.
  - S1 advances into S2 only when S2 is empty or draining.
  - A full S1 behind a stalled S2 deasserts in_ready_o.
- flush_i clears both valid bits on the next edge. A request presented in the flush cycle is dropped.
- flush_i has priority over acceptance and advancement in the same cycle.
- Asynchronous reset mid-transfer discards everything. The first accept is possible in the first cycle after reset deasserts.

## Structure
- Shared md package:
  - md_op field positions: MD_W=3, MD_DIV=2, MD_F1=1, MD_F0=0.
  - funct3 constants MUL..REMU.
  - MD_XLEN=64.
  - The signs_o bit-order definition. The post-processor reads the same package.
- One sub-module, md_operand_ext. It is combinational and handles one operand: extend + signed flag → magnitude, sign. It is instantiated twice between S1 and S2.

## Test plan
- DIV, rs1=-7 (0xFFFF_FFFF_FFFF_FFF9), rs2=2 → a_o=7, b_o=2, signs_o=2'b01, dz=ovf=0, out_valid two cycles after accept.
- MULHSU, rs1=-1, rs2=0xFFFF_FFFF_FFFF_FFFF → a_o=1, b_o=0xFFFF_FFFF_FFFF_FFFF, signs_o=2'b10.
- DIVUW, rs1=0xDEAD_BEEF_8000_0000, rs2=0 → a_o=0x0000_0000_8000_0000, b_o=0, dz_o=1, signs_o=0.
- REM, rs1=0x8000_0000_0000_0000, rs2=-1 → ovf_o=1, a_o=0x8000_0000_0000_0000, b_o=1, signs_o=2'b11.
- Back-to-back 4 requests with out_ready_i held low 3 cycles → in_ready_o drops after 2 accepts, S2 outputs stable, all 4 delivered in order with no loss or duplication.
- flush_i asserted with both stages full and in_valid_i high → next cycle out_valid_o=0, in_ready_o=1, no flushed request ever emitted.
